// File: rtl/mem_if_arb_pkg.sv
// Shared widths, field offsets, command codes and FSM states
// for the memory-interface arbiter.
package mem_if_arb_pkg;

  localparam int REQ_W  = 87;
  localparam int RESP_W = 51;
  localparam int DATA_W = 32;

  localparam int CMD_LSB   = 84;
  localparam int CMD_W     = 3;
  localparam int ID_LSB    = 68;
  localparam int ID_W      = 16;
  localparam int ADDR_LSB  = 36;
  localparam int ADDR_W    = 32;
  localparam int STRB_LSB  = 32;
  localparam int STRB_W    = 4;
  localparam int WDATA_LSB = 0;
  localparam int RDATA_LSB = 0;

  localparam logic [CMD_W-1:0] CMD_RD = 3'd0;
  localparam logic [CMD_W-1:0] CMD_WR = 3'd1;

  localparam logic [DATA_W-1:0] ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_ERR,
    S_DRAIN
  } state_t;

  function automatic logic [RESP_W-1:0] err_resp();
    return {{(RESP_W-DATA_W){1'b0}}, ERR_DATA};
  endfunction

endpackage

// File: rtl/mem_if_rr_arb.sv
// Rotate-priority picker: first valid requester after
// last_grant wins, wrapping modulo N_REQ.
module mem_if_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  int          c;
  logic [IW-1:0] ci;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c  = (int'(last_grant) + k) % N_REQ;
      ci = IW'(c);
      if (!found && valid[ci]) begin
        found     = 1'b1;
        grant[ci] = 1'b1;
        idx       = ci;
      end
    end
  end

endmodule

// File: rtl/mem_if_arb.sv
// N-to-1 memory-interface arbiter with one outstanding
// transaction, response timeout and late-response drain.
module mem_if_arb
  import mem_if_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              s_req_valid_i,
  output logic [N_REQ-1:0]              s_req_ready_o,
  input  logic [N_REQ-1:0][REQ_W-1:0]   s_req_i,
  output logic [N_REQ-1:0]              s_resp_valid_o,
  input  logic [N_REQ-1:0]              s_resp_ready_i,
  output logic [RESP_W-1:0]             s_resp_o,
  output logic                          m_req_valid_o,
  input  logic                          m_req_ready_i,
  output logic [REQ_W-1:0]              m_req_o,
  input  logic                          m_resp_valid_i,
  output logic                          m_resp_ready_o,
  input  logic [RESP_W-1:0]             m_resp_i,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 0) ?
                      $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYC);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  state_t             state_q, state_d;
  logic [IW-1:0]      last_q;
  logic [IW-1:0]      grant_q;
  logic [REQ_W-1:0]   payload_q;
  logic [TW-1:0]      timer_q;

  logic [N_REQ-1:0]   arb_oh;
  logic [IW-1:0]      arb_idx;
  logic               any_req;
  logic               expired;
  logic               resp_hs;
  logic               err_hs;

  mem_if_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .valid      (s_req_valid_i),
    .last_grant (last_q),
    .grant      (arb_oh),
    .idx        (arb_idx)
  );

  assign any_req = |s_req_valid_i;
  // A response in the expiry cycle wins over the timeout.
  assign expired = TO_EN && (timer_q == TO_VAL)
                   && !m_resp_valid_i;
  assign resp_hs = m_resp_valid_i && s_resp_ready_i[grant_q];
  assign err_hs  = s_resp_ready_i[grant_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_REQ;
      S_REQ:   if (m_req_ready_i) state_d = S_RESP;
      S_RESP: begin
        if (resp_hs)      state_d = S_IDLE;
        else if (expired) state_d = S_ERR;
      end
      S_ERR:   if (err_hs) state_d = S_DRAIN;
      S_DRAIN: begin
        if (m_resp_valid_i || expired) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q    <= IW'(N_REQ - 1);
      grant_q   <= '0;
      payload_q <= '0;
      timer_q   <= '0;
    end else begin
      if (state_q == S_IDLE && any_req) begin
        grant_q   <= arb_idx;
        payload_q <= s_req_i[arb_idx];
      end
      if ((state_q == S_RESP && resp_hs) ||
          (state_q == S_ERR && err_hs))
        last_q <= grant_q;
      // REQ and ERR are the only ways into RESP and DRAIN.
      if (state_q == S_REQ || state_q == S_ERR)
        timer_q <= '0;
      else if ((state_q == S_RESP || state_q == S_DRAIN)
               && !m_resp_valid_i && timer_q != '1)
        timer_q <= timer_q + 1'b1;
    end
  end

  always_comb begin
    s_req_ready_o  = '0;
    s_resp_valid_o = '0;
    s_resp_o       = '0;
    m_req_valid_o  = 1'b0;
    m_req_o        = '0;
    m_resp_ready_o = 1'b0;
    busy_o         = 1'b0;
    timeout_o      = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        S_IDLE: s_req_ready_o = arb_oh;
        S_REQ: begin
          busy_o        = 1'b1;
          m_req_valid_o = 1'b1;
          m_req_o       = payload_q;
        end
        S_RESP: begin
          busy_o                  = 1'b1;
          s_resp_valid_o[grant_q] = m_resp_valid_i;
          s_resp_o                = m_resp_i;
          m_resp_ready_o          = s_resp_ready_i[grant_q];
          timeout_o               = expired;
        end
        S_ERR: begin
          busy_o                  = 1'b1;
          s_resp_valid_o[grant_q] = 1'b1;
          s_resp_o                = err_resp();
        end
        S_DRAIN: begin
          busy_o         = 1'b1;
          m_resp_ready_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_if_arb.md
MEM_IF_ARB -- requirements
Module: mem_if_arb

Interface
REQ-001 Parameter N_REQ, default 2, number of upstream memory-interface requesters (2..4).
REQ-002 Parameter TIMEOUT_CYC, default 255, response-wait limit in cycles; 0 disables the timeout.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 s_req_valid_i  in  N_REQ  per-requester request valid.
REQ-006 s_req_ready_o  out  N_REQ  per-requester request accept.
REQ-007 s_req_i  in  N_REQ x 87  per-requester request payload: [86:84] cmd (0 read, 1 write), [83:68] id, [67:36] addr, [35:32] strobe, [31:0] wdata.
REQ-008 s_resp_valid_o  out  N_REQ  per-requester response valid.
REQ-009 s_resp_ready_i  in  N_REQ  per-requester response ready.
REQ-010 s_resp_o  out  51  response payload broadcast to all requesters; [31:0] rdata.
REQ-011 m_req_valid_o / m_req_ready_i / m_req_o  out/in/out  1/1/87  downstream request channel.
REQ-012 m_resp_valid_i / m_resp_ready_o / m_resp_i  in/out/in  1/1/51  downstream response channel.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 timeout_o  out  1  one-cycle pulse on timeout.

Function
REQ-015 FSM states: IDLE, REQ, RESP, ERR, DRAIN.
REQ-016 IDLE: if any s_req_valid_i is high, select winner by round robin starting at last_grant+1 modulo N_REQ; assert s_req_ready_o[winner] that cycle only; latch payload and winner index; go to REQ.
REQ-017 s_req_ready_o is zero in every state except IDLE; only one bit is ever high.
REQ-018 REQ: m_req_valid_o=1, m_req_o = latched payload, held stable until m_req_ready_i; on handshake go to RESP; minimum accept-to-downstream-valid latency 1 cycle.
REQ-019 RESP: s_resp_valid_o[grant]=m_resp_valid_i, s_resp_o=m_resp_i, m_resp_ready_o=s_resp_ready_i[grant]; all other s_resp_valid_o bits 0; on handshake update last_grant=grant and go to IDLE.
REQ-020 Timer: cleared on RESP entry, increments each RESP cycle without m_resp_valid_i; when it equals TIMEOUT_CYC (nonzero), pulse timeout_o and go to ERR.
REQ-021 Simultaneous m_resp_valid_i and timer expiry: the response wins; no timeout.
REQ-022 ERR: s_resp_valid_o[grant]=1, s_resp_o = 51'h0 with [31:0]=32'hFFFF_FFFF, m_resp_ready_o=0; on s_resp_ready_i[grant] go to DRAIN.
REQ-023 DRAIN: m_resp_ready_o=1, no upstream response valid; discard one downstream response then go to IDLE; also exit to IDLE if timer (cleared on entry) reaches TIMEOUT_CYC again.
REQ-024 last_grant updates on every completed transaction, normal or timed-out.
REQ-025 Timer width: clog2(TIMEOUT_CYC+1) bits; saturates, never wraps.

Reset
REQ-026 On rst_i: state IDLE, last_grant=N_REQ-1 (requester 0 first), timer 0, latched payload 0.
REQ-027 All outputs 0 during reset, including m_req_o and s_resp_o.
REQ-028 Reset mid-transaction abandons it; no response is generated afterwards.

Structure
REQ-029 Package mem_if_arb_pkg SHALL hold the 87/51 widths, field offsets, the cmd codes, the state enum and the 32'hFFFF_FFFF error-data constant.
REQ-030 Sub-module mem_if_rr_arb: combinational rotate-priority picker (inputs: valid vector, last_grant; outputs: one-hot grant, index).

Verification
REQ-031 Only req1 valid, write addr 32'h1000_0004 data 32'hA5A5_5A5A -> m_req_o carries it 1 cycle after s_req_ready_o[1]; response routed only to s_resp_valid_o[1].
REQ-032 Both requesters valid continuously, 4 transactions -> grants 0,1,0,1.
REQ-033 m_req_ready_i low for 5 cycles -> m_req_valid_o held, m_req_o unchanged throughout.
REQ-034 TIMEOUT_CYC=8, no response -> timeout_o pulse after 8 RESP cycles, requester sees data 32'hFFFF_FFFF; late response 3 cycles later is dropped; next grant goes to the other requester.
REQ-035 Response arriving on the expiry cycle -> normal response delivered, timeout_o stays 0.
REQ-036 rst_i asserted in RESP -> all outputs 0 immediately; after release, req0 is served first.
